// File: rtl/vie_fetch_pkg.sv
// Shared definitions for the instruction fetch pipe.
//   - parameter defaults for the fetch pipe
//   - ADEL exception code
//   - instruction buffer entry layout and its packed width
//   - fetch state encoding
package vie_fetch_pkg;

  localparam int          MAX_OUTST_DEF  = 2;
  localparam int          IBUF_DEPTH_DEF = 4;
  localparam logic [31:0] RESET_PC_DEF   = 32'hbfc00000;

  // Exception code reported downstream for a misaligned fetch address.
  localparam logic [4:0]  EXC_ADEL = 5'h04;

  localparam int PC_W   = 32;
  localparam int INST_W = 32;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
    logic              adel;
  } ibuf_entry_t;

  localparam int ENTRY_W = $bits(ibuf_entry_t);

  typedef enum logic {
    FS_RUN   = 1'b0,
    FS_STALL = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/vie_ibuf_fifo.sv
// Instruction buffer: synchronous circular FIFO.
// Ports:
//   clock, reset      : rising-edge clock, synchronous active-high reset
//   clear             : synchronous flush of all entries (wins over push)
//   push, push_data   : write one entry; accepted when not full or when
//                       a pop happens in the same cycle
//   pop, pop_data     : pop_data is the head entry; pop is ignored when empty
//   count, full, empty: occupancy status
module vie_ibuf_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 65
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             pop_eff;
  logic             push_eff;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign pop_eff  = pop && !empty;
  // Full-and-popping still frees the head slot this cycle.
  assign push_eff = push && (!full || pop_eff);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_eff) wr_ptr <= wr_ptr + AW'(1);
      if (pop_eff)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_eff, pop_eff})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push_eff && !clear) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/vie_fetch_pipe.sv
// Instruction fetch pipe: issues SRAM-like fetch requests, tracks
// outstanding responses, cancels stale responses on redirects and feeds
// decode through a small instruction buffer.
// Ports:
//   clock, reset                 : rising-edge clock, sync active-high reset
//   flush_valid/flush_pc         : exception/eret redirect (highest priority)
//   br_valid/br_pc               : branch redirect from decode
//   inst_req/inst_addr           : request, held until inst_addr_ok
//   inst_addr_ok                 : request accepted
//   inst_data_ok/inst_rdata      : in-order read data
//   ds_allowin                   : decode takes the head entry this cycle
//   ds_valid/ds_pc/ds_inst       : head entry presented to decode
//   ds_adel/ds_badvaddr          : fetch address error and faulting address
//
// state    | meaning
// FS_RUN   | fetching normally, or waiting to push an ADEL entry
// FS_STALL | ADEL entry pushed; no fetching until the next redirect
module vie_fetch_pipe
  import vie_fetch_pkg::*;
#(
  parameter int          MAX_OUTST  = MAX_OUTST_DEF,
  parameter int          IBUF_DEPTH = IBUF_DEPTH_DEF,
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush_valid,
  input  logic [31:0] flush_pc,
  input  logic        br_valid,
  input  logic [31:0] br_pc,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  input  logic        ds_allowin,
  output logic        ds_valid,
  output logic [31:0] ds_pc,
  output logic [31:0] ds_inst,
  output logic        ds_adel,
  output logic [31:0] ds_badvaddr
);

  localparam int CNT_W = $clog2(MAX_OUTST + 1);
  localparam int IB_CW = $clog2(IBUF_DEPTH) + 1;

  fetch_state_t      state;
  fetch_state_t      state_nxt;

  logic [31:0]       fetch_pc;
  logic [31:0]       pend_pc;
  logic              pend_valid;
  logic              req_hold;
  logic [CNT_W-1:0]  outst_cnt;
  logic [CNT_W-1:0]  cancel_cnt;
  logic [CNT_W-1:0]  outst_nxt;
  logic [CNT_W-1:0]  cancel_nxt;
  logic [CNT_W-1:0]  pcq_wr_idx;
  logic [31:0]       pcq [MAX_OUTST];

  logic              redirect;
  logic [31:0]       redir_pc;
  logic              misaligned;
  logic              credit_ok;
  logic              can_issue;
  logic              accept;
  logic              held_now;
  logic              keep_data;
  logic              adel_push;

  logic              ib_push;
  logic              ib_pop;
  ibuf_entry_t       ib_wdata;
  ibuf_entry_t       ib_head;
  logic [ENTRY_W-1:0] ib_head_bits;
  logic [IB_CW-1:0]  ib_count;
  logic              ib_full;
  logic              ib_empty;

  assign redirect   = flush_valid || br_valid;
  assign redir_pc   = flush_valid ? flush_pc : br_pc;
  assign misaligned = (fetch_pc[1:0] != 2'b00);

  // Cancelled responses still occupy credit until they drain, which keeps
  // the buffer from ever being asked to take more than it can hold.
  assign credit_ok  = (int'(outst_cnt) < MAX_OUTST) &&
                      ((int'(outst_cnt) + int'(ib_count)) < IBUF_DEPTH);
  assign can_issue  = (state == FS_RUN) && !misaligned && credit_ok;

  assign inst_req   = !reset && (req_hold || can_issue);
  assign inst_addr  = fetch_pc;
  assign accept     = inst_req && inst_addr_ok;
  assign held_now   = inst_req && !inst_addr_ok;

  // Data arriving in a redirect cycle belongs to the old path.
  assign keep_data  = inst_data_ok && (cancel_cnt == '0) && !redirect;
  assign ib_pop     = ds_valid && ds_allowin;

  // Misaligned fetch_pc only arises from a redirect, after which every
  // outstanding response is cancelled; waiting for outst==cancel keeps the
  // ADEL entry from racing a kept response.
  assign adel_push  = (state == FS_RUN) && misaligned && !redirect &&
                      (outst_cnt == cancel_cnt) && (!ib_full || ib_pop);
  assign ib_push    = keep_data || adel_push;

  always_comb begin
    ib_wdata = '0;
    if (adel_push) begin
      ib_wdata.pc   = fetch_pc;
      ib_wdata.adel = 1'b1;
    end else begin
      ib_wdata.pc   = pcq[0];
      ib_wdata.inst = inst_rdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state <= FS_RUN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FS_RUN:   if (adel_push) state_nxt = FS_STALL;
      FS_STALL: if (redirect)  state_nxt = FS_RUN;
      default:  state_nxt = FS_RUN;
    endcase
  end

  always_comb begin
    outst_nxt = outst_cnt;
    case ({accept, inst_data_ok})
      2'b10:   outst_nxt = outst_cnt + CNT_W'(1);
      2'b01:   outst_nxt = outst_cnt - CNT_W'(1);
      default: outst_nxt = outst_cnt;
    endcase

    cancel_nxt = cancel_cnt;
    if (redirect) begin
      // Everything still in flight after this edge is stale.
      cancel_nxt = outst_nxt;
    end else begin
      // A request held across a redirect is stale once it is accepted.
      if (accept && pend_valid)
        cancel_nxt = cancel_nxt + CNT_W'(1);
      if (inst_data_ok && (cancel_cnt != '0))
        cancel_nxt = cancel_nxt - CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc   <= RESET_PC;
      pend_pc    <= '0;
      pend_valid <= 1'b0;
      req_hold   <= 1'b0;
      outst_cnt  <= '0;
      cancel_cnt <= '0;
    end else begin
      outst_cnt  <= outst_nxt;
      cancel_cnt <= cancel_nxt;
      req_hold   <= held_now;
      if (redirect) begin
        if (held_now) begin
          pend_valid <= 1'b1;
          pend_pc    <= redir_pc;
        end else begin
          pend_valid <= 1'b0;
          fetch_pc   <= redir_pc;
        end
      end else if (accept) begin
        if (pend_valid) begin
          fetch_pc   <= pend_pc;
          pend_valid <= 1'b0;
        end else begin
          fetch_pc   <= fetch_pc + 32'd4;
        end
      end
    end
  end

  // In-order PC tags: pcq[0] is the PC of the oldest outstanding request.
  assign pcq_wr_idx = inst_data_ok ? (outst_cnt - CNT_W'(1)) : outst_cnt;

  always_ff @(posedge clock) begin
    if (inst_data_ok) begin
      for (int i = 0; i < MAX_OUTST - 1; i++) pcq[i] <= pcq[i+1];
    end
    for (int i = 0; i < MAX_OUTST; i++) begin
      if (accept && (int'(pcq_wr_idx) == i)) pcq[i] <= fetch_pc;
    end
  end

  vie_ibuf_fifo #(
    .DEPTH (IBUF_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_ibuf (
    .clock     (clock),
    .reset     (reset),
    .clear     (redirect),
    .push      (ib_push),
    .push_data (ib_wdata),
    .pop       (ib_pop),
    .pop_data  (ib_head_bits),
    .count     (ib_count),
    .full      (ib_full),
    .empty     (ib_empty)
  );

  assign ib_head     = ibuf_entry_t'(ib_head_bits);
  assign ds_valid    = !ib_empty;
  assign ds_pc       = ds_valid ? ib_head.pc   : 32'd0;
  assign ds_inst     = ds_valid ? ib_head.inst : 32'd0;
  assign ds_adel     = ds_valid && ib_head.adel;
  assign ds_badvaddr = (ds_valid && ib_head.adel) ? ib_head.pc : 32'd0;

endmodule
